// File: rtl/int_to_fp.sv
// int_to_fp: pipelined signed-integer / fixed-point to floating-point converter.
// Four register stages with one conversion accepted per clock and no backpressure.
// Output fields are sign / biased exponent / stored fraction, with no denormals.
// Optional macro INT_TO_FP_RNE_EN selects round-to-nearest-even.
// When the macro is not defined, the fraction is truncated (round toward zero).
module int_to_fp #(
    parameter int EXPONENT_SIZE        = 8,
    parameter int MANTISSA_SIZE        = 7,
    parameter int INT_SIZE             = 16,
    parameter int FIXED_POINT_POSITION = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     din_valid,
    input  logic [INT_SIZE-1:0]      din,
    output logic                     dout_valid,
    output logic                     sign,
    output logic [EXPONENT_SIZE-1:0] exponent,
    output logic [MANTISSA_SIZE-1:0] mantissa
);

    localparam int LZC_W   = $clog2(INT_SIZE) + 1;
    localparam int BIAS    = (1 << (EXPONENT_SIZE - 1)) - 1;
    localparam int EXP_MAX = (1 << EXPONENT_SIZE) - 1;
    localparam int EXP_OFS = INT_SIZE - 1 - FIXED_POINT_POSITION;
    // The bits below the hidden one, followed by MANTISSA_SIZE+1 zeros.
    // Fraction and guard always exist, even for narrow inputs.
    localparam int PAD_W   = INT_SIZE + MANTISSA_SIZE;

    // Stage 1 registers
    logic                r_s1_valid, r_s1_sign, r_s1_zero;
    logic [INT_SIZE-1:0] r_s1_mag;
    logic [INT_SIZE-1:0] w_s1_mag;

    // Stage 2 registers
    logic                r_s2_valid, r_s2_sign, r_s2_zero;
    logic [INT_SIZE-1:0] r_s2_mag;
    logic [LZC_W-1:0]    r_s2_lzc;
    logic [LZC_W-1:0]    w_s2_lzc;

    // Stage 3 registers
    logic                     r_s3_valid, r_s3_sign, r_s3_zero;
    logic                     r_s3_guard, r_s3_sticky;
    logic [MANTISSA_SIZE-1:0] r_s3_frac;
    logic signed [31:0]       r_s3_exp;
    logic                     w_s3_unused_hidden;
    logic [INT_SIZE-2:0]      w_s3_below;
    logic [PAD_W-1:0]         w_s3_pad;
    logic signed [31:0]       w_s3_exp;

    // Stage 4 rounding
    logic                     w_s4_round_up;
    logic [MANTISSA_SIZE:0]   w_s4_sum;
    logic signed [31:0]       w_s4_biased;

    // Magnitude of the two's-complement input.
    // The most-negative value maps to 2^(INT_SIZE-1), which still fits in INT_SIZE bits.
    assign w_s1_mag = din[INT_SIZE-1] ? (~din + INT_SIZE'(1)) : din;

    // Stage 1: capture the sign, the magnitude and the zero flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_sign  <= 1'b0;
            r_s1_zero  <= 1'b0;
            r_s1_mag   <= '0;
        end else begin
            // NOTE: pipeline state uses non-blocking assignments so every stage samples the previous stage's old value.
            r_s1_valid <= din_valid;
            if (din_valid) begin
                r_s1_sign <= din[INT_SIZE-1];
                r_s1_zero <= (din == '0);
                r_s1_mag  <= w_s1_mag;
            end
        end
    end

    // Leading-zero count: the highest set bit wins, because the loop scans upward.
    always_comb begin
        // NOTE: a default before the loop keeps this purely combinational (no latch).
        w_s2_lzc = LZC_W'(INT_SIZE);
        for (int i = 0; i < INT_SIZE; i++) begin
            if (r_s1_mag[i]) w_s2_lzc = LZC_W'(INT_SIZE - 1 - i);
        end
    end

    // Stage 2: register the leading-zero count alongside the magnitude.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_sign  <= 1'b0;
            r_s2_zero  <= 1'b0;
            r_s2_mag   <= '0;
            r_s2_lzc   <= '0;
        end else begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_sign <= r_s1_sign;
                r_s2_zero <= r_s1_zero;
                r_s2_mag  <= r_s1_mag;
                r_s2_lzc  <= w_s2_lzc;
            end
        end
    end

    // Normalise so the hidden 1 sits at the MSB, then split off the bits below it.
    assign {w_s3_unused_hidden, w_s3_below} = r_s2_mag << r_s2_lzc;
    assign w_s3_pad = {w_s3_below, {(MANTISSA_SIZE + 1){1'b0}}};
    assign w_s3_exp = EXP_OFS - int'(r_s2_lzc);

    // Stage 3: register the unbiased exponent and the fraction/guard/sticky fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s3_valid  <= 1'b0;
            r_s3_sign   <= 1'b0;
            r_s3_zero   <= 1'b0;
            r_s3_frac   <= '0;
            r_s3_guard  <= 1'b0;
            r_s3_sticky <= 1'b0;
            r_s3_exp    <= '0;
        end else begin
            r_s3_valid <= r_s2_valid;
            if (r_s2_valid) begin
                r_s3_sign   <= r_s2_sign;
                r_s3_zero   <= r_s2_zero;
                r_s3_frac   <= w_s3_pad[PAD_W-1 -: MANTISSA_SIZE];
                r_s3_guard  <= w_s3_pad[INT_SIZE-1];
                r_s3_sticky <= |w_s3_pad[INT_SIZE-2:0];
                r_s3_exp    <= w_s3_exp;
            end
        end
    end

`ifdef INT_TO_FP_RNE_EN
    // Round to nearest; an exact tie goes to the even fraction.
    assign w_s4_round_up = r_s3_guard & (r_s3_sticky | r_s3_frac[0]);
`else
    // Truncation: guard and sticky are produced but deliberately ignored.
    logic w_s4_unused_rnd;
    assign w_s4_unused_rnd = r_s3_guard | r_s3_sticky;
    assign w_s4_round_up   = 1'b0;
`endif

    // A carry out of the fraction leaves a zero fraction and bumps the exponent.
    assign w_s4_sum    = {1'b0, r_s3_frac} + (MANTISSA_SIZE + 1)'(w_s4_round_up);
    assign w_s4_biased = r_s3_exp + int'(w_s4_sum[MANTISSA_SIZE]) + BIAS;

    // Stage 4: bias the exponent, then apply zero, underflow-flush and overflow-saturate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_valid <= 1'b0;
            sign       <= 1'b0;
            exponent   <= '0;
            mantissa   <= '0;
        end else begin
            dout_valid <= r_s3_valid;
            if (r_s3_valid) begin
                if (r_s3_zero || (w_s4_biased <= 0)) begin
                    sign     <= 1'b0;
                    exponent <= '0;
                    mantissa <= '0;
                end else if (w_s4_biased >= EXP_MAX) begin
                    sign     <= r_s3_sign;
                    exponent <= EXPONENT_SIZE'(EXP_MAX - 1);
                    mantissa <= '1;
                end else begin
                    sign     <= r_s3_sign;
                    exponent <= w_s4_biased[EXPONENT_SIZE-1:0];
                    mantissa <= w_s4_sum[MANTISSA_SIZE-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_int_to_fp.sv
// tb_int_to_fp: table-driven scoreboard bench for int_to_fp.
// Three instances are used: the default format, a fixed-point build with FIXED_POINT_POSITION=4, and a narrow E3/M3 build.
// The narrow build reaches the underflow and overflow boundaries.
// Expected values follow the rounding mode selected by INT_TO_FP_RNE_EN.
module tb_int_to_fp;

`ifdef INT_TO_FP_RNE_EN
    localparam bit RNE = 1'b1;
`else
    localparam bit RNE = 1'b0;
`endif

    typedef struct {
        int          unit;
        logic [15:0] din;
        logic        s;
        logic [7:0]  e;
        logic [6:0]  m;
    } vec_t;

    typedef struct {
        logic       s;
        logic [7:0] e;
        logic [6:0] m;
        int         due;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   mon_en   = 1'b0;

    logic        vin [3];
    logic [15:0] dn  [3];
    logic        v0, s0, v1, s1, v2, s2;
    logic [7:0]  e0, e1;
    logic [6:0]  m0, m1;
    logic [2:0]  e2, m2;

    exp_t        q    [3][$];
    logic [15:0] last [3];
    vec_t        tbl  [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int_to_fp u_def (
        .clk(clk), .rst_n(rst_n), .din_valid(vin[0]), .din(dn[0]),
        .dout_valid(v0), .sign(s0), .exponent(e0), .mantissa(m0)
    );

    int_to_fp #(.FIXED_POINT_POSITION(4)) u_fp4 (
        .clk(clk), .rst_n(rst_n), .din_valid(vin[1]), .din(dn[1]),
        .dout_valid(v1), .sign(s1), .exponent(e1), .mantissa(m1)
    );

    int_to_fp #(.EXPONENT_SIZE(3), .MANTISSA_SIZE(3), .INT_SIZE(16), .FIXED_POINT_POSITION(8)) u_small (
        .clk(clk), .rst_n(rst_n), .din_valid(vin[2]), .din(dn[2]),
        .dout_valid(v2), .sign(s2), .exponent(e2), .mantissa(m2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, want, cyc);
    endtask

    // Compares one output sample against the scoreboard.
    // Outside a valid cycle it checks that the fields still hold their last value.
    task automatic check_out(input int u, input logic v, input logic s,
                             input logic [7:0] e, input logic [6:0] m);
        exp_t x;
        logic due;
        if (v === 1'b1) begin
            if (q[u].size() == 0) begin
                check($sformatf("u%0d_unexpected_valid", u), 32'(v), 32'd0);
            end else begin
                x = q[u].pop_front();
                check($sformatf("u%0d_fields", u), {16'd0, s, e, m}, {16'd0, x.s, x.e, x.m});
                check($sformatf("u%0d_latency", u), cyc, x.due);
                last[u] = {x.s, x.e, x.m};
            end
        end else begin
            due = (q[u].size() != 0) && (q[u][0].due <= cyc);
            check($sformatf("u%0d_valid", u), 32'(v), 32'(due));
            check($sformatf("u%0d_hold", u), {16'd0, s, e, m}, {16'd0, last[u]});
            if (due) void'(q[u].pop_front());
        end
    endtask

    always @(negedge clk) if (mon_en && rst_n) check_out(0, v0, s0, e0, m0);
    always @(negedge clk) if (mon_en && rst_n) check_out(1, v1, s1, e1, m1);
    always @(negedge clk) if (mon_en && rst_n) check_out(2, v2, s2, {5'd0, e2}, {4'd0, m2});

    task automatic send(input int u, input logic v, input logic [15:0] d,
                        input logic s, input logic [7:0] e, input logic [6:0] m);
        exp_t x;
        @(negedge clk);
        for (int k = 0; k < 3; k++) vin[k] = 1'b0;
        vin[u] = v;
        dn[u]  = d;
        if (v) begin
            x.s = s; x.e = e; x.m = m; x.due = cyc + 4;
            q[u].push_back(x);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) vin[k] = 1'b0;
        end
    endtask

    function automatic void add(input int u, input logic [15:0] d, input logic s,
                                input logic [7:0] e, input logic [6:0] m);
        vec_t t;
        t.unit = u; t.din = d; t.s = s; t.e = e; t.m = m;
        tbl.push_back(t);
    endfunction

    initial begin
        // Default format E8/M7, integer input
        add(0, 16'h0001, 1'b0, 8'h7F, 7'h00);
        add(0, 16'hFFFF, 1'b1, 8'h7F, 7'h00);
        add(0, 16'h0000, 1'b0, 8'h00, 7'h00);
        add(0, 16'h8000, 1'b1, 8'h8E, 7'h00);
        add(0, 16'h7FFF, 1'b0, RNE ? 8'h8E : 8'h8D, RNE ? 7'h00 : 7'h7F);
        add(0, 16'h0103, 1'b0, 8'h87, RNE ? 7'h02 : 7'h01);
        add(0, 16'h0101, 1'b0, 8'h87, 7'h00);
        add(0, 16'h01FF, 1'b0, RNE ? 8'h88 : 8'h87, RNE ? 7'h00 : 7'h7F);
        add(0, 16'hFEFD, 1'b1, 8'h87, RNE ? 7'h02 : 7'h01);
        add(0, 16'h0002, 1'b0, 8'h80, 7'h00);
        add(0, 16'h0003, 1'b0, 8'h80, 7'h40);
        add(0, 16'h8001, 1'b1, RNE ? 8'h8E : 8'h8D, RNE ? 7'h00 : 7'h7F);
        add(0, 16'h00FF, 1'b0, 8'h86, 7'h7F);
        add(0, 16'h0180, 1'b0, 8'h87, 7'h40);
        add(0, 16'hFFFB, 1'b1, 8'h81, 7'h20);
        add(0, 16'h4000, 1'b0, 8'h8D, 7'h00);
        add(0, 16'h0105, 1'b0, 8'h87, 7'h02);
        add(0, 16'h0107, 1'b0, 8'h87, RNE ? 7'h04 : 7'h03);
        add(0, 16'h0405, 1'b0, 8'h89, RNE ? 7'h01 : 7'h00);
        // Fixed point, 4 fractional bits
        add(1, 16'h0018, 1'b0, 8'h7F, 7'h40);
        add(1, 16'h0001, 1'b0, 8'h7B, 7'h00);
        add(1, 16'hFFF0, 1'b1, 8'h7F, 7'h00);
        add(1, 16'h0000, 1'b0, 8'h00, 7'h00);
        // E3/M3 with 8 fractional bits: bias 3, largest finite exponent 6
        add(2, 16'h0001, 1'b0, 8'h0, 7'h0);
        add(2, 16'h0020, 1'b0, 8'h0, 7'h0);
        add(2, 16'h0040, 1'b0, 8'h1, 7'h0);
        add(2, 16'h0100, 1'b0, 8'h3, 7'h0);
        add(2, 16'h0800, 1'b0, 8'h6, 7'h0);
        add(2, 16'h0F00, 1'b0, 8'h6, 7'h7);
        add(2, 16'h0F80, 1'b0, 8'h6, 7'h7);
        add(2, 16'h0E90, 1'b0, 8'h6, RNE ? 7'h7 : 7'h6);
        add(2, 16'h1000, 1'b0, 8'h6, 7'h7);
        add(2, 16'h8000, 1'b1, 8'h6, 7'h7);
        add(2, 16'hFFE0, 1'b0, 8'h0, 7'h0);

        for (int k = 0; k < 3; k++) begin
            vin[k] = 1'b0; dn[k] = '0; last[k] = '0;
        end

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_valid0", 32'(v0), 32'd0);
        check("reset_fields0", {16'd0, s0, e0, m0}, 32'd0);
        check("reset_valid1", 32'(v1), 32'd0);
        check("reset_fields1", {16'd0, s1, e1, m1}, 32'd0);
        check("reset_valid2", 32'(v2), 32'd0);
        check("reset_fields2", {25'd0, s2, e2, m2}, 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        mon_en = 1'b1;

        // Back-to-back table vectors
        foreach (tbl[i]) send(tbl[i].unit, 1'b1, tbl[i].din, tbl[i].s, tbl[i].e, tbl[i].m);

        // Valid pattern 1,0,1,1,0,1; bubble data must not disturb anything
        idle(2);
        send(0, 1'b1, 16'h0003, 1'b0, 8'h80, 7'h40);
        send(0, 1'b0, 16'h7FFF, 1'b0, 8'h00, 7'h00);
        send(0, 1'b1, 16'hFFFB, 1'b1, 8'h81, 7'h20);
        send(0, 1'b1, 16'h0101, 1'b0, 8'h87, 7'h00);
        send(0, 1'b0, 16'h1234, 1'b0, 8'h00, 7'h00);
        send(0, 1'b1, 16'h0002, 1'b0, 8'h80, 7'h00);
        idle(8);

        // Reset pulse with three conversions in flight
        send(0, 1'b1, 16'h0103, 1'b0, 8'h87, 7'h01);
        send(0, 1'b1, 16'h01FF, 1'b0, 8'h87, 7'h7F);
        send(0, 1'b1, 16'h8000, 1'b1, 8'h8E, 7'h00);
        @(negedge clk);
        for (int k = 0; k < 3; k++) vin[k] = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_valid", 32'(v0), 32'd0);
        check("rst_async_fields", {16'd0, s0, e0, m0}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            q[k].delete();
            last[k] = '0;
        end
        @(posedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            check("rst_flush_valid", 32'(v0), 32'd0);
            check("rst_flush_fields", {16'd0, s0, e0, m0}, 32'd0);
        end

        // A fresh conversion after reset comes through normally
        send(0, 1'b1, 16'h0018, 1'b0, 8'h83, 7'h40);
        idle(8);

        for (int k = 0; k < 3; k++) check($sformatf("u%0d_drain", k), 32'(q[k].size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
